// File: rtl/mem_arbiter_if.sv
// -----------------------------------------------------------------------------
// mem_arbiter_if
// Bundles the two requester ports and the block-RAM port that mem_arbiter
// arbitrates between.
//   req0/req1, we0/we1, addr0/addr1, wdata0/wdata1 : requester side, to arbiter
//   gnt0/gnt1, rvalid0/rvalid1, rdata              : arbiter to requesters
//   mem_addr, mem_din, mem_write                   : arbiter to block RAM
//   mem_dout                                       : block RAM to arbiter
// Modports:
//   slave  - seen by the arbiter
//   master - seen by the requesters / RAM model driving the arbiter
// -----------------------------------------------------------------------------
interface mem_arbiter_if #(
    parameter int ADDR_W = 15,
    parameter int DATA_W = 16
);
    logic              req0;
    logic              req1;
    logic              we0;
    logic              we1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic [DATA_W-1:0] wdata0;
    logic [DATA_W-1:0] wdata1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_din;
    logic              mem_write;
    logic [DATA_W-1:0] mem_dout;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
        output gnt0, gnt1, rvalid0, rvalid1, rdata, mem_addr, mem_din, mem_write
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_dout,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata, mem_addr, mem_din, mem_write
    );
endinterface

// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
// Two-requester arbiter in front of a single-port block RAM. A requester owns
// the port while its grant is high; every cycle with grant and request is an
// access. Ownership is handed over without an idle gap when the owner drops its
// request, or when it has used MAX_BURST accesses while the other requester
// waits.
// Ports:
//   clk   - single clock, all state on posedge
//   reset - asynchronous, active-high
//   bus   - mem_arbiter_if.slave (requester handshakes + block RAM port)
// Parameters:
//   ADDR_W    - word address width
//   DATA_W    - data width
//   MAX_BURST - accesses an owner may make while the other requester waits
//               (1..255)
// Build option:
//   MEM_ARB_RR_EN - when defined, simultaneous requests seen from IDLE go to
//                   the requester that did not own the port last; otherwise
//                   requester 0 always wins that tie.
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int ADDR_W    = 15,
    parameter int DATA_W    = 16,
    parameter int MAX_BURST = 8
) (
    input  logic           clk,
    input  logic           reset,
    mem_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);

    state_t     state;
    state_t     state_next;
    logic [7:0] burst_cnt;
    logic [7:0] burst_inc;
    logic [7:0] burst_next;
    logic       acc0;
    logic       acc1;
    logic       rd0_vld_p1;
    logic       rd1_vld_p1;
    state_t     tie_winner;

    assign acc0 = (state == OWN0) && bus.req0;
    assign acc1 = (state == OWN1) && bus.req1;

    assign bus.gnt0    = (state == OWN0);
    assign bus.gnt1    = (state == OWN1);
    assign bus.rvalid0 = rd0_vld_p1;
    assign bus.rvalid1 = rd1_vld_p1;
    assign bus.rdata   = bus.mem_dout;

    // Memory port mux: an ungranted request never reaches the RAM.
    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_din   = '0;
        bus.mem_write = 1'b0;
        if (acc0) begin
            bus.mem_addr  = bus.addr0;
            bus.mem_din   = bus.wdata0;
            bus.mem_write = bus.we0;
        end else if (acc1) begin
            bus.mem_addr  = bus.addr1;
            bus.mem_din   = bus.wdata1;
            bus.mem_write = bus.we1;
        end
    end

    // Burst count including this cycle's access, saturating at the limit, so
    // the handover decision sees the access that is happening right now.
    always_comb begin
        burst_inc = burst_cnt;
        if ((acc0 || acc1) && (burst_cnt < BURST_LIM)) begin
            burst_inc = burst_cnt + 8'd1;
        end
    end

`ifdef MEM_ARB_RR_EN
    // 1 = requester 1 owned the port most recently.
    logic last_owner;

    assign tie_winner = last_owner ? OWN0 : OWN1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_owner <= 1'b1;
        end else if ((state_next == OWN0) && (state != OWN0)) begin
            last_owner <= 1'b0;
        end else if ((state_next == OWN1) && (state != OWN1)) begin
            last_owner <= 1'b1;
        end
    end
`else
    assign tie_winner = OWN0;
`endif

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (bus.req0 && bus.req1) begin
                    state_next = tie_winner;
                end else if (bus.req0) begin
                    state_next = OWN0;
                end else if (bus.req1) begin
                    state_next = OWN1;
                end
            end
            OWN0: begin
                if (!bus.req0) begin
                    state_next = bus.req1 ? OWN1 : IDLE;
                end else if (bus.req1 && (burst_inc >= BURST_LIM)) begin
                    state_next = OWN1;
                end
            end
            OWN1: begin
                if (!bus.req1) begin
                    state_next = bus.req0 ? OWN0 : IDLE;
                end else if (bus.req0 && (burst_inc >= BURST_LIM)) begin
                    state_next = OWN0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // A new owner (or IDLE) starts counting from zero.
    assign burst_next = ((state_next != state) || (state_next == IDLE)) ? 8'd0 : burst_inc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Stage p1: read strobe aligned with mem_dout; reset drops an in-flight read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            burst_cnt  <= 8'd0;
            rd0_vld_p1 <= 1'b0;
            rd1_vld_p1 <= 1'b0;
        end else begin
            burst_cnt  <= burst_next;
            rd0_vld_p1 <= acc0 && !bus.we0;
            rd1_vld_p1 <= acc1 && !bus.we1;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
// Directed bench for mem_arbiter (MAX_BURST = 4) with a one-cycle-latency
// block RAM model. A table of per-cycle vectors covers reads, writes,
// handover and burst alternation; hand-written sequences cover reset during
// an in-flight read and the simultaneous-request tie break.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic clk;
    logic reset;
    int   checks;
    int   failures;

    mem_arbiter_if #(.ADDR_W(15), .DATA_W(16)) bus ();

    mem_arbiter #(.ADDR_W(15), .DATA_W(16), .MAX_BURST(4)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Block RAM model: registered read, write on mem_write, preload under reset.
    logic [15:0] ram [0:32767];
    always @(posedge clk) begin
        if (reset) begin
            ram[15'h2400] <= 16'h1234;
        end else if (bus.mem_write) begin
            ram[bus.mem_addr] <= bus.mem_din;
        end
        bus.mem_dout <= ram[bus.mem_addr];
    end

    typedef struct {
        logic        r0, r1, w0, w1;
        logic [14:0] a0, a1;
        logic [15:0] d0, d1;
        logic        g0, g1, v0, v1, mw;
        logic [14:0] ma;
        logic [15:0] md;
        logic        rchk;
        logic [15:0] rd;
    } vec_t;

    localparam int NV = 21;
    vec_t vecs [NV];

    function automatic vec_t mk(input logic r0, r1, w0, w1,
                                input logic [14:0] a0, a1,
                                input logic [15:0] d0, d1,
                                input logic g0, g1, v0, v1, mw,
                                input logic [14:0] ma,
                                input logic [15:0] md,
                                input logic rchk,
                                input logic [15:0] rd);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.w0 = w0; v.w1 = w1;
        v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        v.g0 = g0; v.g1 = g1; v.v0 = v0; v.v1 = v1; v.mw = mw;
        v.ma = ma; v.md = md; v.rchk = rchk; v.rd = rd;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] got=%h expected=%h", nm, idx, act, exp);
        end
    endtask

    task automatic drive(input logic r0, r1, w0, w1,
                         input logic [14:0] a0, a1,
                         input logic [15:0] d0, d1);
        bus.req0 = r0; bus.req1 = r1; bus.we0 = w0; bus.we1 = w1;
        bus.addr0 = a0; bus.addr1 = a1; bus.wdata0 = d0; bus.wdata1 = d1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        checks   = 0;
        failures = 0;

        //          r0 r1 w0 w1 a0        a1        d0        d1     | g0 g1 v0 v1 mw ma        md        rchk rd
        vecs[0]  = mk(1, 0, 0, 0, 15'h2400, 15'h0000, 16'h0000, 16'h0, 0, 0, 0, 0, 0, 15'h0000, 16'h0000, 0, 16'h0000);
        vecs[1]  = mk(1, 0, 0, 0, 15'h2400, 15'h0000, 16'h0000, 16'h0, 1, 0, 0, 0, 0, 15'h2400, 16'h0000, 0, 16'h0000);
        vecs[2]  = mk(0, 0, 0, 0, 15'h0000, 15'h0000, 16'h0000, 16'h0, 1, 0, 1, 0, 0, 15'h0000, 16'h0000, 1, 16'h1234);
        vecs[3]  = mk(1, 0, 1, 0, 15'h3000, 15'h0000, 16'hBEEF, 16'h0, 0, 0, 0, 0, 0, 15'h0000, 16'h0000, 0, 16'h0000);
        vecs[4]  = mk(1, 0, 1, 0, 15'h3000, 15'h0000, 16'hBEEF, 16'h0, 1, 0, 0, 0, 1, 15'h3000, 16'hBEEF, 0, 16'h0000);
        vecs[5]  = mk(0, 1, 0, 0, 15'h0000, 15'h3000, 16'h0000, 16'h0, 1, 0, 0, 0, 0, 15'h0000, 16'h0000, 0, 16'h0000);
        vecs[6]  = mk(0, 1, 0, 0, 15'h0000, 15'h3000, 16'h0000, 16'h0, 0, 1, 0, 0, 0, 15'h3000, 16'h0000, 0, 16'h0000);
        vecs[7]  = mk(0, 0, 0, 0, 15'h0000, 15'h0000, 16'h0000, 16'h0, 0, 1, 0, 1, 0, 15'h0000, 16'h0000, 1, 16'hBEEF);
        vecs[8]  = mk(0, 0, 0, 0, 15'h0000, 15'h0000, 16'h0000, 16'h0, 0, 0, 0, 0, 0, 15'h0000, 16'h0000, 0, 16'h0000);
        vecs[9]  = mk(1, 1, 0, 0, 15'h0010, 15'h0020, 16'h0000, 16'h0, 0, 0, 0, 0, 0, 15'h0000, 16'h0000, 0, 16'h0000);
        vecs[10] = mk(1, 1, 0, 0, 15'h0010, 15'h0020, 16'h0000, 16'h0, 1, 0, 0, 0, 0, 15'h0010, 16'h0000, 0, 16'h0000);
        vecs[11] = mk(1, 1, 0, 0, 15'h0010, 15'h0020, 16'h0000, 16'h0, 1, 0, 1, 0, 0, 15'h0010, 16'h0000, 0, 16'h0000);
        vecs[12] = mk(1, 1, 0, 0, 15'h0010, 15'h0020, 16'h0000, 16'h0, 1, 0, 1, 0, 0, 15'h0010, 16'h0000, 0, 16'h0000);
        vecs[13] = mk(1, 1, 0, 0, 15'h0010, 15'h0020, 16'h0000, 16'h0, 1, 0, 1, 0, 0, 15'h0010, 16'h0000, 0, 16'h0000);
        // Requester 0 keeps requesting (as a write) while requester 1 owns the port.
        vecs[14] = mk(1, 1, 1, 0, 15'h0010, 15'h0020, 16'hDEAD, 16'h0, 0, 1, 1, 0, 0, 15'h0020, 16'h0000, 0, 16'h0000);
        vecs[15] = mk(1, 1, 1, 0, 15'h0010, 15'h0020, 16'hDEAD, 16'h0, 0, 1, 0, 1, 0, 15'h0020, 16'h0000, 0, 16'h0000);
        vecs[16] = mk(1, 1, 1, 0, 15'h0010, 15'h0020, 16'hDEAD, 16'h0, 0, 1, 0, 1, 0, 15'h0020, 16'h0000, 0, 16'h0000);
        vecs[17] = mk(1, 1, 1, 0, 15'h0010, 15'h0020, 16'hDEAD, 16'h0, 0, 1, 0, 1, 0, 15'h0020, 16'h0000, 0, 16'h0000);
        vecs[18] = mk(1, 1, 0, 0, 15'h0010, 15'h0020, 16'h0000, 16'h0, 1, 0, 0, 1, 0, 15'h0010, 16'h0000, 0, 16'h0000);
        vecs[19] = mk(0, 0, 0, 0, 15'h0000, 15'h0000, 16'h0000, 16'h0, 1, 0, 1, 0, 0, 15'h0000, 16'h0000, 0, 16'h0000);
        vecs[20] = mk(0, 0, 0, 0, 15'h0000, 15'h0000, 16'h0000, 16'h0, 0, 0, 0, 0, 0, 15'h0000, 16'h0000, 0, 16'h0000);

        // Reset state
        reset = 1'b1;
        drive(0, 0, 0, 0, 15'h0, 15'h0, 16'h0, 16'h0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_gnt0", 0, 32'(bus.gnt0), 32'd0);
        chk("rst_gnt1", 0, 32'(bus.gnt1), 32'd0);
        chk("rst_rvalid0", 0, 32'(bus.rvalid0), 32'd0);
        chk("rst_rvalid1", 0, 32'(bus.rvalid1), 32'd0);
        chk("rst_mem_write", 0, 32'(bus.mem_write), 32'd0);
        chk("rst_mem_addr", 0, 32'(bus.mem_addr), 32'd0);
        next_cycle();
        reset = 1'b0;

        // Table-driven cycles
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].r0, vecs[i].r1, vecs[i].w0, vecs[i].w1,
                  vecs[i].a0, vecs[i].a1, vecs[i].d0, vecs[i].d1);
            @(negedge clk);
            chk("gnt0", i, 32'(bus.gnt0), 32'(vecs[i].g0));
            chk("gnt1", i, 32'(bus.gnt1), 32'(vecs[i].g1));
            chk("rvalid0", i, 32'(bus.rvalid0), 32'(vecs[i].v0));
            chk("rvalid1", i, 32'(bus.rvalid1), 32'(vecs[i].v1));
            chk("mem_write", i, 32'(bus.mem_write), 32'(vecs[i].mw));
            chk("mem_addr", i, 32'(bus.mem_addr), 32'(vecs[i].ma));
            chk("mem_din", i, 32'(bus.mem_din), 32'(vecs[i].md));
            if (vecs[i].rchk) chk("rdata", i, 32'(bus.rdata), 32'(vecs[i].rd));
            next_cycle();
        end

        // Reset asserted the cycle after a granted read
        drive(1, 0, 0, 0, 15'h2400, 15'h0, 16'h0, 16'h0);
        next_cycle();
        chk("pre_gnt0", 0, 32'(bus.gnt0), 32'd1);
        next_cycle();
        chk("pre_rvalid0", 0, 32'(bus.rvalid0), 32'd1);
        reset = 1'b1;
        #1;
        chk("ar_rvalid0", 0, 32'(bus.rvalid0), 32'd0);
        chk("ar_gnt0", 0, 32'(bus.gnt0), 32'd0);
        chk("ar_gnt1", 0, 32'(bus.gnt1), 32'd0);
        chk("ar_mem_write", 0, 32'(bus.mem_write), 32'd0);
        @(negedge clk);
        chk("ar_rvalid0", 1, 32'(bus.rvalid0), 32'd0);
        chk("ar_mem_addr", 1, 32'(bus.mem_addr), 32'd0);
        next_cycle();
        reset = 1'b0;
        #1;
        chk("rel_gnt0", 0, 32'(bus.gnt0), 32'd0);
        chk("rel_rvalid0", 0, 32'(bus.rvalid0), 32'd0);
        next_cycle();
        chk("rel_gnt0", 1, 32'(bus.gnt0), 32'd1);

        // Simultaneous requests from IDLE, two rounds after reset
        reset = 1'b1;
        drive(0, 0, 0, 0, 15'h0, 15'h0, 16'h0, 16'h0);
        next_cycle();
        reset = 1'b0;
        drive(1, 1, 0, 0, 15'h0040, 15'h0050, 16'h0, 16'h0);
        next_cycle();
        chk("tie1_gnt0", 0, 32'(bus.gnt0), 32'd1);
        chk("tie1_gnt1", 0, 32'(bus.gnt1), 32'd0);
        drive(0, 0, 0, 0, 15'h0, 15'h0, 16'h0, 16'h0);
        next_cycle();
        chk("tie_idle_gnt0", 0, 32'(bus.gnt0), 32'd0);
        chk("tie_idle_gnt1", 0, 32'(bus.gnt1), 32'd0);
        drive(1, 1, 0, 0, 15'h0040, 15'h0050, 16'h0, 16'h0);
        next_cycle();
`ifdef MEM_ARB_RR_EN
        chk("tie2_gnt0", 0, 32'(bus.gnt0), 32'd0);
        chk("tie2_gnt1", 0, 32'(bus.gnt1), 32'd1);
        chk("tie2_mem_addr", 0, 32'(bus.mem_addr), 32'h0050);
`else
        chk("tie2_gnt0", 0, 32'(bus.gnt0), 32'd1);
        chk("tie2_gnt1", 0, 32'(bus.gnt1), 32'd0);
        chk("tie2_mem_addr", 0, 32'(bus.mem_addr), 32'h0040);
`endif
        drive(0, 0, 0, 0, 15'h0, 15'h0, 16'h0, 16'h0);
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
